// File: rtl/rtm_seq_alu.sv
// Sequencer/ALU stage in front of the RTM register file.
// Runs each instruction through IDLE, READ, EXEC and WB, then writes back.
module rtm_seq_alu #(
    parameter int n = 16,
    parameter int k = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3*k+3:0]   instr,
    input  logic [n-1:0]     imm,
    input  logic [n-1:0]     rf_a,
    input  logic [n-1:0]     rf_b,
    output logic [n-1:0]     rf_x,
    output logic             rf_ld,
    output logic [k-1:0]     rf_d,
    output logic [k-1:0]     rf_sa,
    output logic [k-1:0]     rf_sb,
    output logic             flag_z,
    output logic             flag_c,
    output logic             done,
    output logic             illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;

    state_t         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [k-1:0]   d_q, d_d;
    logic [k-1:0]   sa_q, sa_d;
    logic [k-1:0]   sb_q, sb_d;
    logic [n-1:0]   imm_q, imm_d;
    logic [n-1:0]   a_q, a_d;
    logic [n-1:0]   b_q, b_d;
    logic [n-1:0]   res_q, res_d;
    logic           z_q, z_d;
    logic           c_q, c_d;
    logic           wr_q, wr_d;
    logic           ill_q, ill_d;

    logic [n:0]     sum;
    logic [n:0]     diff;
    logic [n-1:0]   alu_res;
    logic           alu_c;
    logic           alu_wr;
    logic           alu_upd;
    logic           alu_ill;

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
        alu_ill = 1'b0;
        unique case (op_q)
            OP_NOP: begin
                alu_wr  = 1'b0;
                alu_upd = 1'b0;
            end
            OP_ADD: begin
                alu_res = sum[n-1:0];
                alu_c   = sum[n];
            end
            OP_SUB: begin
                alu_res = diff[n-1:0];
                alu_c   = diff[n];
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_SHL: begin
                alu_res = {a_q[n-2:0], 1'b0};
                alu_c   = a_q[n-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[n-1:1]};
                alu_c   = a_q[0];
            end
            OP_MOV: alu_res = a_q;
            OP_LDI: alu_res = imm_q;
            OP_CMP: begin
                alu_res = diff[n-1:0];
                alu_c   = diff[n];
                alu_wr  = 1'b0;
            end
            default: begin
                alu_wr  = 1'b0;
                alu_upd = 1'b0;
                alu_ill = 1'b1;
            end
        endcase
    end

    assign instr_ready = rst_n & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        d_d     = d_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        imm_d   = imm_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        z_d     = z_q;
        c_d     = c_q;
        wr_d    = wr_q;
        ill_d   = ill_q;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    op_d    = instr[3*k+3:3*k];
                    d_d     = instr[3*k-1:2*k];
                    sa_d    = instr[2*k-1:k];
                    sb_d    = instr[k-1:0];
                    imm_d   = imm;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d     = rf_a;
                b_d     = rf_b;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // NOP and reserved ops leave result and flags untouched
                if (alu_upd) begin
                    res_d = alu_res;
                    z_d   = (alu_res == '0);
                    c_d   = alu_c;
                end
                wr_d    = alu_wr;
                ill_d   = alu_ill;
                state_d = S_WB;
            end
            S_WB: begin
                wr_d    = 1'b0;
                ill_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            d_q     <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            d_q     <= d_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            imm_q   <= imm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            z_q     <= z_d;
            c_q     <= c_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
        end
    end

    assign rf_x    = res_q;
    assign rf_d    = d_q;
    assign rf_sa   = sa_q;
    assign rf_sb   = sb_q;
    assign flag_z  = z_q;
    assign flag_c  = c_q;
    assign done    = (state_q == S_WB);
    assign rf_ld   = (state_q == S_WB) & wr_q;
    assign illegal = (state_q == S_WB) & ill_q;

endmodule

// File: tb/tb_rtm_seq_alu.sv
// Bench for rtm_seq_alu: a behavioural register file, a reference model
// and a queue of expected write-back results checked at each done pulse.
module tb_rtm_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [15:0] imm = '0;
    logic [15:0] rf_a;
    logic [15:0] rf_b;
    logic [15:0] rf_x;
    logic        rf_ld;
    logic [3:0]  rf_d;
    logic [3:0]  rf_sa;
    logic [3:0]  rf_sb;
    logic        flag_z;
    logic        flag_c;
    logic        done;
    logic        illegal;

    rtm_seq_alu #(.n(16), .k(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .imm(imm),
        .rf_a(rf_a), .rf_b(rf_b),
        .rf_x(rf_x), .rf_ld(rf_ld), .rf_d(rf_d),
        .rf_sa(rf_sa), .rf_sb(rf_sb),
        .flag_z(flag_z), .flag_c(flag_c),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] regs [16] = '{default: 16'h0000};
    assign rf_a = regs[rf_sa];
    assign rf_b = regs[rf_sb];
    always @(posedge clk) if (rf_ld) regs[rf_d] <= rf_x;

    typedef struct {
        logic        ld;
        logic [3:0]  d;
        logic [15:0] x;
        logic        z;
        logic        c;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] mreg [16] = '{default: 16'h0000};
    logic        mz = 1'b0;
    logic        mc = 1'b0;
    int          last_acc = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic [15:0] im);
        exp_t e;
        logic [16:0] s;
        logic upd;
        e.ld = 1'b1; e.d = '0; e.x = '0; e.z = mz; e.c = mc;
        e.ill = 1'b0; e.cyc = 0; upd = 1'b1;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            4'h0: begin e.ld = 0; upd = 0; end
            4'h1: begin e.x = s[15:0]; e.c = s[16]; end
            4'h2: begin e.x = a - b; e.c = (a < b); end
            4'h3: begin e.x = a & b; e.c = 0; end
            4'h4: begin e.x = a | b; e.c = 0; end
            4'h5: begin e.x = a ^ b; e.c = 0; end
            4'h6: begin e.x = ~a; e.c = 0; end
            4'h7: begin e.x = a << 1; e.c = a[15]; end
            4'h8: begin e.x = a >> 1; e.c = a[0]; end
            4'h9: begin e.x = a; e.c = 0; end
            4'hA: begin e.x = im; e.c = 0; end
            4'hB: begin e.x = a - b; e.c = (a < b); e.ld = 0; end
            default: begin e.ld = 0; upd = 0; e.ill = 1; end
        endcase
        if (upd) e.z = (e.x == 16'h0000);
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [3:0] d,
                         input logic [3:0] sa, input logic [3:0] sb,
                         input logic [15:0] im, input bit hold,
                         input bit chk_gap);
        bit got;
        exp_t e;
        instr_valid = 1'b1;
        instr = {op, d, sa, sb};
        imm = im;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (instr_ready) got = 1;
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            if (chk_gap) check("accept_gap", cyc - last_acc, 32'd4);
            last_acc = cyc;
            e = model(op, mreg[sa], mreg[sb], im);
            e.d = d;
            e.cyc = cyc + 3;
            if (e.ld) mreg[d] = e.x;
            mz = e.z;
            mc = e.c;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_ld && !done) check("ld_outside_wb", 32'd1, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("rf_ld", {31'd0, rf_ld}, {31'd0, e.ld});
                    if (e.ld) begin
                        check("rf_d", {28'd0, rf_d}, {28'd0, e.d});
                        check("rf_x", {16'd0, rf_x}, {16'd0, e.x});
                    end
                    check("flag_z", {31'd0, flag_z}, {31'd0, e.z});
                    check("flag_c", {31'd0, flag_c}, {31'd0, e.c});
                    check("illegal", {31'd0, illegal}, {31'd0, e.ill});
                end
            end else begin
                check("illegal_no_done", {31'd0, illegal}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] outs_or();
        return {16'd0, rf_x} | {28'd0, rf_d} | {28'd0, rf_sa} |
               {28'd0, rf_sb} |
               {27'd0, flag_z, flag_c, done, illegal, rf_ld} |
               {31'd0, instr_ready};
    endfunction

    initial begin
        logic [15:0] saved;
        #3;
        check("reset_outputs_zero", outs_or(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;

        issue(4'hA, 4'd3, 4'd0, 4'd0, 16'h00FF, 0, 0);
        issue(4'hA, 4'd4, 4'd0, 4'd0, 16'h0001, 0, 0);
        issue(4'h1, 4'd5, 4'd3, 4'd4, 16'h0000, 0, 0);

        issue(4'hA, 4'd6, 4'd0, 4'd0, 16'hFFFF, 0, 0);
        issue(4'hA, 4'd7, 4'd0, 4'd0, 16'h0001, 0, 0);
        issue(4'h1, 4'd8, 4'd6, 4'd7, 16'h0000, 0, 0);
        issue(4'h2, 4'd9, 4'd7, 4'd6, 16'h0000, 0, 0);

        issue(4'hA, 4'd10, 4'd0, 4'd0, 16'h1234, 0, 0);
        issue(4'hB, 4'd10, 4'd10, 4'd10, 16'h0000, 0, 0);
        issue(4'hE, 4'd10, 4'd3, 4'd4, 16'h0000, 0, 0);

        issue(4'hA, 4'd11, 4'd0, 4'd0, 16'h8001, 0, 0);
        issue(4'h7, 4'd12, 4'd11, 4'd0, 16'h0000, 0, 0);
        issue(4'h8, 4'd13, 4'd11, 4'd0, 16'h0000, 0, 0);

        issue(4'h3, 4'd1, 4'd3, 4'd11, 16'h0000, 1, 0);
        issue(4'h6, 4'd2, 4'd3, 4'd0, 16'hAAAA, 1, 1);
        issue(4'h5, 4'd14, 4'd2, 4'd11, 16'h5555, 1, 1);
        instr = 16'hFFFF;
        imm = 16'hDEAD;
        issue(4'h9, 4'd3, 4'd3, 4'd0, 16'h0000, 0, 1);

        saved = mreg[1];
        issue(4'h1, 4'd1, 4'd3, 4'd4, 16'h0000, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs_or(), 32'd0);
        exp_q.delete();
        mreg[1] = saved;
        mz = 1'b0;
        mc = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hold_outputs", outs_or(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_first_cycle", {31'd0, instr_ready}, 32'd1);
        check("reg1_not_written", {16'd0, regs[1]}, {16'd0, saved});
        @(posedge clk);
        #1;

        issue(4'h9, 4'd15, 4'd5, 4'd0, 16'h0000, 0, 0);
        issue(4'h2, 4'd15, 4'd15, 4'd15, 16'h0000, 0, 0);

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("rf_mirror_r5", {16'd0, regs[5]}, {16'd0, mreg[5]});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
